multicycle_ctrl: RTL and testbench

Control sequencer that turns the processor's datapath (PC, shared instruction/data memory port, register file, ALU, immediate generator) into a multicycle RV32I machine. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every datapath select and write strobe, and tells the immediate generator which format to produce. It sits beside the datapath top level and replaces the purely combinational decode of the single-cycle build.

---
 rtl/rv_ctrl_pkg.sv | 77 +++++++
 rtl/multicycle_ctrl_if.sv | 30 +++
 rtl/alu_op_decoder.sv | 33 +++
 rtl/multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, states and select encodings for the multicycle RV32I control path
package rv_ctrl_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic logic [2:0] imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: imm_type_of = IMM_I;
      OP_STORE:                                      imm_type_of = IMM_S;
      OP_BRANCH:                                     imm_type_of = IMM_B;
      OP_LUI, OP_AUIPC:                              imm_type_of = IMM_U;
      OP_JAL:                                        imm_type_of = IMM_J;
      default:                                       imm_type_of = IMM_NONE;
    endcase
  endfunction

  function automatic logic is_exec_opcode(input logic [6:0] opcode);
    case (opcode)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: is_exec_opcode = 1'b1;
      default:                           is_exec_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/datapath bundle between the sequencer and the datapath
interface multicycle_ctrl_if;
  logic [31:0] inst;
  logic        mem_ready;
  logic        branch_taken;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [1:0]  pc_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;
  logic [2:0]  imm_type;

  modport master (
    input  inst, mem_ready, branch_taken,
    output ir_we, pc_we, rf_we, mem_req, mem_we, mem_addr_sel,
           pc_sel, alu_a_sel, alu_b_sel, alu_op, wb_sel, imm_type
  );

  modport slave (
    output inst, mem_ready, branch_taken,
    input  ir_we, pc_we, rf_we, mem_req, mem_we, mem_addr_sel,
           pc_sel, alu_a_sel, alu_b_sel, alu_op, wb_sel, imm_type
  );
endinterface

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - maps opcode/funct3/inst[30] to the ALU operation code
module alu_op_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  logic is_r;

  always_comb begin
    alu_op = ALU_ADD;
    is_r   = (opcode == OP_OP);
    if (opcode == OP_OP || opcode == OP_IMM) begin
      case (funct3)
        3'b000:  alu_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        // inst[30] selects arithmetic shift in both R and I forms
        3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end else if (opcode == OP_BRANCH) begin
      alu_op = ALU_SUB;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I multicycle datapath
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  multicycle_ctrl_if.master        bus,
  output logic [2:0]               state,
  output logic                     illegal
);

  state_t     state_q;
  state_t     state_d;
  logic       set_illegal;
  logic       ir_we_d;
  logic       pc_we_d;
  logic       rf_we_d;
  logic       mem_req_d;
  logic       mem_we_d;
  logic [6:0] opcode;
  logic [3:0] dec_alu_op;

  assign opcode = bus.inst[6:0];

  alu_op_decoder u_alu_op_decoder (
    .opcode   (opcode),
    .funct3   (bus.inst[14:12]),
    .funct7_5 (bus.inst[30]),
    .alu_op   (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    set_illegal      = 1'b0;
    ir_we_d          = 1'b0;
    pc_we_d          = 1'b0;
    rf_we_d          = 1'b0;
    mem_req_d        = 1'b0;
    mem_we_d         = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.pc_sel       = PC_PLUS4;
    bus.alu_a_sel    = ALU_A_RS1;
    bus.alu_b_sel    = ALU_B_RS2;
    bus.alu_op       = ALU_ADD;
    bus.wb_sel       = WB_ALU;
    bus.imm_type     = IMM_I;

    if (state_q != ST_FETCH && state_q != ST_HALT) begin
      bus.imm_type = imm_type_of(opcode);
    end

    // The ALU is combinational: operands stay applied through MEM/WB so the
    // address (loads/stores) and rs1+imm (JALR) remain valid where consumed.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      bus.alu_op = dec_alu_op;
      case (opcode)
        OP_IMM, OP_LOAD, OP_STORE, OP_JALR: begin
          bus.alu_b_sel = ALU_B_IMM;
        end
        OP_LUI: begin
          bus.alu_a_sel = ALU_A_ZERO;
          bus.alu_b_sel = ALU_B_IMM;
        end
        OP_AUIPC: begin
          bus.alu_a_sel = ALU_A_PC;
          bus.alu_b_sel = ALU_B_IMM;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_FETCH: begin
        mem_req_d = 1'b1;
        if (bus.mem_ready) begin
          ir_we_d = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_exec_opcode(opcode)) begin
          state_d = ST_EXEC;
        end else if (opcode == OP_FENCE) begin
          pc_we_d = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d     = ST_HALT;
          set_illegal = (opcode != OP_SYSTEM);
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          OP_BRANCH: begin
            pc_we_d    = 1'b1;
            bus.pc_sel = bus.branch_taken ? PC_IMM : PC_PLUS4;
            state_d    = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req_d        = 1'b1;
        bus.mem_addr_sel = 1'b1;
        mem_we_d         = (opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we_d = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we_d = 1'b1;
        pc_we_d = 1'b1;
        state_d = ST_FETCH;
        case (opcode)
          OP_LOAD: bus.wb_sel = WB_MEM;
          OP_JAL: begin
            bus.wb_sel = WB_PC4;
            bus.pc_sel = PC_IMM;
          end
          OP_JALR: begin
            bus.wb_sel = WB_PC4;
            bus.pc_sel = PC_ALU;
          end
          default: ;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase
  end

  // Strobes are masked by rst in the same cycle so an aborted access never writes.
  assign bus.ir_we   = ir_we_d   & ~rst;
  assign bus.pc_we   = pc_we_d   & ~rst;
  assign bus.rf_we   = rf_we_d   & ~rst;
  assign bus.mem_req = mem_req_d & ~rst;
  assign bus.mem_we  = mem_we_d  & ~rst;

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       illegal;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state   (state),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       ill;
    logic       ir_we, pc_we, rf_we, mem_req, mem_we, mas;
    logic [1:0] pcs, as;
    logic       bs;
    logic [3:0] op;
    logic [1:0] wb;
    logic [2:0] it;
  } snap_t;

  snap_t tr [64];
  int tests = 0;
  int fails = 0;

  // Drives one cycle per bit of rdy/rstm and records the combinational outputs mid-cycle.
  task automatic run_trace(input logic [31:0] ins, input int n, input logic [31:0] rdy,
                           input logic tk, input logic [31:0] rstm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.inst = ins;
      bus.mem_ready = rdy[i];
      bus.branch_taken = tk;
      rst = rstm[i];
      #1;
      tr[i].st = state;        tr[i].ill = illegal;
      tr[i].ir_we = bus.ir_we; tr[i].pc_we = bus.pc_we; tr[i].rf_we = bus.rf_we;
      tr[i].mem_req = bus.mem_req; tr[i].mem_we = bus.mem_we; tr[i].mas = bus.mem_addr_sel;
      tr[i].pcs = bus.pc_sel;  tr[i].as = bus.alu_a_sel; tr[i].bs = bus.alu_b_sel;
      tr[i].op = bus.alu_op;   tr[i].wb = bus.wb_sel;    tr[i].it = bus.imm_type;
    end
  endtask

  task automatic test_reset;
    run_trace(32'h00500093, 3, 32'h3, 1'b0, 32'h3);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({tr[i].ir_we, tr[i].pc_we, tr[i].rf_we, tr[i].mem_req, tr[i].mem_we} !== 5'b0) begin
        fails++; $display("FAIL reset_strobes[%0d] got %b exp 00000", i,
          {tr[i].ir_we, tr[i].pc_we, tr[i].rf_we, tr[i].mem_req, tr[i].mem_we});
      end
    end
    tests++; if (tr[2].st !== 3'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", tr[2].st); end
    tests++; if (tr[2].ill !== 1'b0) begin fails++; $display("FAIL reset_illegal got %b exp 0", tr[2].ill); end
    tests++; if (tr[2].mem_req !== 1'b1) begin fails++; $display("FAIL reset_fetch_req got %b exp 1", tr[2].mem_req); end
  endtask

  task automatic test_addi;
    int es[5] = '{0, 1, 2, 4, 0};
    int npc = 0;
    run_trace(32'h00500093, 5, 32'h0F, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (tr[i].st !== 3'(es[i])) begin fails++; $display("FAIL addi_state[%0d] got %0d exp %0d", i, tr[i].st, es[i]); end
      if (i < 4) npc += int'(tr[i].pc_we);
    end
    tests++; if (tr[0].ir_we !== 1'b1) begin fails++; $display("FAIL addi_ir_we got %b exp 1", tr[0].ir_we); end
    tests++; if (tr[2].bs !== 1'b1) begin fails++; $display("FAIL addi_alu_b got %b exp 1", tr[2].bs); end
    tests++; if (tr[2].op !== 4'd0) begin fails++; $display("FAIL addi_alu_op got %0d exp 0", tr[2].op); end
    tests++; if (tr[2].it !== 3'd0) begin fails++; $display("FAIL addi_imm got %0d exp 0", tr[2].it); end
    tests++; if (tr[3].rf_we !== 1'b1) begin fails++; $display("FAIL addi_rf_we got %b exp 1", tr[3].rf_we); end
    tests++; if (tr[3].wb !== 2'd0) begin fails++; $display("FAIL addi_wb_sel got %0d exp 0", tr[3].wb); end
    tests++; if (tr[3].pcs !== 2'd0) begin fails++; $display("FAIL addi_pc_sel got %0d exp 0", tr[3].pcs); end
    tests++; if (npc != 1) begin fails++; $display("FAIL addi_pc_we_count got %0d exp 1", npc); end
  endtask

  task automatic test_fetch_wait;
    int es[7] = '{0, 0, 0, 1, 2, 4, 0};
    run_trace(32'h00500093, 7, 32'h3C, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (tr[i].st !== 3'(es[i])) begin fails++; $display("FAIL fwait_state[%0d] got %0d exp %0d", i, tr[i].st, es[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (tr[i].mem_req !== 1'b1 || tr[i].mas !== 1'b0) begin
        fails++; $display("FAIL fwait_req[%0d] got req=%b sel=%b exp req=1 sel=0", i, tr[i].mem_req, tr[i].mas);
      end
    end
    tests++; if (tr[3].mem_req !== 1'b0) begin fails++; $display("FAIL fwait_req_drop got %b exp 0", tr[3].mem_req); end
  endtask

  task automatic test_load;
    int es[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    run_trace(32'h0000A103, 9, 32'h0C7, 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (tr[i].st !== 3'(es[i])) begin fails++; $display("FAIL load_state[%0d] got %0d exp %0d", i, tr[i].st, es[i]); end
    end
    for (int i = 3; i < 7; i++) begin
      tests++;
      if ({tr[i].mem_req, tr[i].mas, tr[i].mem_we} !== 3'b110) begin
        fails++; $display("FAIL load_mem[%0d] got req/sel/we=%b exp 110", i, {tr[i].mem_req, tr[i].mas, tr[i].mem_we});
      end
    end
    tests++; if (tr[7].wb !== 2'd1) begin fails++; $display("FAIL load_wb_sel got %0d exp 1", tr[7].wb); end
    tests++; if (tr[7].rf_we !== 1'b1) begin fails++; $display("FAIL load_rf_we got %b exp 1", tr[7].rf_we); end
    tests++; if (tr[7].mem_req !== 1'b0) begin fails++; $display("FAIL load_req_drop got %b exp 0", tr[7].mem_req); end
  endtask

  task automatic test_branch;
    int es[4] = '{0, 1, 2, 0};
    for (int t = 0; t < 2; t++) begin
      int nrf = 0;
      run_trace(32'h00208463, 4, 32'h7, t[0], 32'h0);
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (tr[i].st !== 3'(es[i])) begin fails++; $display("FAIL br%0d_state[%0d] got %0d exp %0d", t, i, tr[i].st, es[i]); end
        nrf += int'(tr[i].rf_we);
      end
      tests++; if (tr[2].pcs !== 2'(t)) begin fails++; $display("FAIL br%0d_pc_sel got %0d exp %0d", t, tr[2].pcs, t); end
      tests++; if (tr[2].pc_we !== 1'b1) begin fails++; $display("FAIL br%0d_pc_we got %b exp 1", t, tr[2].pc_we); end
      tests++; if (tr[2].op !== 4'd1) begin fails++; $display("FAIL br%0d_alu_op got %0d exp 1", t, tr[2].op); end
      tests++; if (tr[2].it !== 3'd2) begin fails++; $display("FAIL br%0d_imm got %0d exp 2", t, tr[2].it); end
      tests++; if (nrf != 0) begin fails++; $display("FAIL br%0d_rf_we got %0d exp 0", t, nrf); end
    end
  endtask

  task automatic test_alu_decode;
    logic [31:0] ins[5] = '{32'h402081B3, 32'h4010D193, 32'h40008093, 32'h0020D1B3, 32'h0020F1B3};
    logic [3:0]  eop[5] = '{4'd1, 4'd7, 4'd0, 4'd6, 4'd2};
    logic        ebs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      run_trace(ins[k], 5, 32'h0F, 1'b0, 32'h0);
      tests++; if (tr[2].op !== eop[k]) begin fails++; $display("FAIL dec%0d_alu_op got %0d exp %0d", k, tr[2].op, eop[k]); end
      tests++; if (tr[2].bs !== ebs[k]) begin fails++; $display("FAIL dec%0d_alu_b got %b exp %b", k, tr[2].bs, ebs[k]); end
      tests++; if (tr[4].st !== 3'd0) begin fails++; $display("FAIL dec%0d_end_state got %0d exp 0", k, tr[4].st); end
    end
    tests++; if (tr[1].it !== 3'd7) begin fails++; $display("FAIL rtype_imm got %0d exp 7", tr[1].it); end
  endtask

  task automatic test_store;
    int es[5] = '{0, 1, 2, 3, 0};
    int nrf = 0;
    run_trace(32'h0020A223, 5, 32'h0F, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (tr[i].st !== 3'(es[i])) begin fails++; $display("FAIL st_state[%0d] got %0d exp %0d", i, tr[i].st, es[i]); end
      nrf += int'(tr[i].rf_we);
    end
    tests++; if (tr[1].it !== 3'd1) begin fails++; $display("FAIL st_imm got %0d exp 1", tr[1].it); end
    tests++;
    if ({tr[3].mem_req, tr[3].mas, tr[3].mem_we, tr[3].pc_we} !== 4'b1111) begin
      fails++; $display("FAIL st_mem got req/sel/we/pcwe=%b exp 1111", {tr[3].mem_req, tr[3].mas, tr[3].mem_we, tr[3].pc_we});
    end
    tests++; if (nrf != 0) begin fails++; $display("FAIL st_rf_we got %0d exp 0", nrf); end
  endtask

  task automatic test_store_reset;
    int es[6] = '{0, 1, 2, 3, 3, 0};
    int npc = 0;
    run_trace(32'h0020A223, 6, 32'h17, 1'b0, 32'h10);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (tr[i].st !== 3'(es[i])) begin fails++; $display("FAIL strst_state[%0d] got %0d exp %0d", i, tr[i].st, es[i]); end
      npc += int'(tr[i].pc_we);
    end
    tests++; if (tr[3].mem_we !== 1'b1) begin fails++; $display("FAIL strst_we_before got %b exp 1", tr[3].mem_we); end
    tests++;
    if ({tr[4].mem_req, tr[4].mem_we, tr[4].pc_we} !== 3'b000) begin
      fails++; $display("FAIL strst_abort got req/we/pcwe=%b exp 000", {tr[4].mem_req, tr[4].mem_we, tr[4].pc_we});
    end
    tests++; if (npc != 0) begin fails++; $display("FAIL strst_pc_we got %0d exp 0", npc); end
  endtask

  task automatic test_jumps;
    run_trace(32'h008000EF, 5, 32'h0F, 1'b0, 32'h0);
    tests++; if (tr[1].it !== 3'd4) begin fails++; $display("FAIL jal_imm got %0d exp 4", tr[1].it); end
    tests++; if (tr[3].st !== 3'd4) begin fails++; $display("FAIL jal_state got %0d exp 4", tr[3].st); end
    tests++;
    if ({tr[3].wb, tr[3].pcs, tr[3].rf_we, tr[3].pc_we} !== 6'b10_01_11) begin
      fails++; $display("FAIL jal_wb got wb/pcs/rf/pc=%b exp 100111", {tr[3].wb, tr[3].pcs, tr[3].rf_we, tr[3].pc_we});
    end
    run_trace(32'h000080E7, 5, 32'h0F, 1'b0, 32'h0);
    tests++; if (tr[2].bs !== 1'b1) begin fails++; $display("FAIL jalr_exec_b got %b exp 1", tr[2].bs); end
    tests++;
    if ({tr[3].wb, tr[3].pcs, tr[3].bs, tr[3].as, tr[3].op} !== 11'b10_10_1_00_0000) begin
      fails++; $display("FAIL jalr_wb got %b exp 10101000000", {tr[3].wb, tr[3].pcs, tr[3].bs, tr[3].as, tr[3].op});
    end
    tests++; if (tr[4].st !== 3'd0) begin fails++; $display("FAIL jalr_end got %0d exp 0", tr[4].st); end
  endtask

  task automatic test_back_to_back;
    run_trace(32'h123450B7, 5, 32'h0F, 1'b0, 32'h0);
    tests++; if ({tr[2].as, tr[2].bs, tr[2].it} !== 6'b10_1_011) begin
      fails++; $display("FAIL lui_exec got %b exp 101011", {tr[2].as, tr[2].bs, tr[2].it});
    end
    run_trace(32'h00000097, 5, 32'h0F, 1'b0, 32'h0);
    tests++; if ({tr[2].as, tr[2].bs, tr[2].op} !== 7'b01_1_0000) begin
      fails++; $display("FAIL auipc_exec got %b exp 0110000", {tr[2].as, tr[2].bs, tr[2].op});
    end
    tests++; if (tr[3].st !== 3'd4) begin fails++; $display("FAIL auipc_wb_state got %0d exp 4", tr[3].st); end
    run_trace(32'h0000000F, 3, 32'h3, 1'b0, 32'h0);
    tests++;
    if ({tr[1].pc_we, tr[1].pcs, tr[1].rf_we, tr[2].st} !== 7'b1_00_0_000) begin
      fails++; $display("FAIL fence got pcwe/pcs/rf/next=%b exp 1000000", {tr[1].pc_we, tr[1].pcs, tr[1].rf_we, tr[2].st});
    end
  endtask

  task automatic test_illegal;
    int bad = 0;
    run_trace(32'hFFFFFFFF, 24, 32'h003FFFFF, 1'b0, 32'h00400000);
    tests++; if (tr[1].st !== 3'd1) begin fails++; $display("FAIL ill_decode got %0d exp 1", tr[1].st); end
    tests++; if (tr[1].ill !== 1'b0) begin fails++; $display("FAIL ill_early got %b exp 0", tr[1].ill); end
    for (int i = 2; i < 23; i++) begin
      if (tr[i].st !== 3'd5 || tr[i].ill !== 1'b1 ||
          {tr[i].ir_we, tr[i].pc_we, tr[i].rf_we, tr[i].mem_req, tr[i].mem_we} !== 5'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL ill_halt_cycles got %0d bad exp 0", bad); end
    tests++; if (tr[23].st !== 3'd0) begin fails++; $display("FAIL ill_rst_state got %0d exp 0", tr[23].st); end
    tests++; if (tr[23].ill !== 1'b0) begin fails++; $display("FAIL ill_rst_flag got %b exp 0", tr[23].ill); end
    run_trace(32'h00000073, 6, 32'h1, 1'b0, 32'h0);
    tests++; if ({tr[5].st, tr[5].ill} !== 4'b101_0) begin
      fails++; $display("FAIL ecall_halt got st/ill=%b exp 1010", {tr[5].st, tr[5].ill});
    end
    run_trace(32'h00000073, 2, 32'h0, 1'b0, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    bus.inst = 32'h0;
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
    test_reset;
    test_addi;
    test_fetch_wait;
    test_load;
    test_branch;
    test_alu_decode;
    test_store;
    test_store_reset;
    test_jumps;
    test_back_to_back;
    test_illegal;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
